apb_reg_bank: RTL and testbench
===============================

APB_REG_BANK -- requirements
Module: apb_reg_bank

Interface
REQ-001 SHALL have parameter G_APB_ADDR_WIDTH, default 8: APB byte-address width; register index = paddr_i[G_APB_ADDR_WIDTH-1:2].
REQ-002 SHALL have parameter G_NUM_REGS, default 8: number of 32-bit registers, 1..2^(G_APB_ADDR_WIDTH-2).
REQ-003 SHALL have parameter G_WAIT_CYCLES, default 0: APB wait states inserted per transfer, 0..15.
REQ-004 SHALL have parameter G_RO_MASK, G_NUM_REGS bits, default 0: bit i=1 makes register i read-only, sourced from hardware.
REQ-005 SHALL have parameter G_W1C_MASK, G_NUM_REGS*32 bits, default 0: per-bit write-1-to-clear, hardware-set bits in RW registers.
REQ-006 SHALL have parameter G_RESET_VALUE, G_NUM_REGS*32 bits, default 0: per-register reset value.
REQ-007 SHALL have parameter G_PRIV_WRITE, default 0: when 1, writes require pprot_i[0]=1.
REQ-008 pclk_i  in  1  single clock; all logic on rising edge.
REQ-009 preset_n_i  in  1  reset, synchronous, active-low.
REQ-010 paddr_i  in  G_APB_ADDR_WIDTH  APB byte address.
REQ-011 pprot_i  in  3  APB protection; only bit 0 (privileged) is used.
REQ-012 psel_i, penable_i, pwrite_i  in  1 each  APB control.
REQ-013 pwdata_i  in  32  write data; pstrb_i  in  4  byte-lane strobes.
REQ-014 pready_o  out  1; prdata_o  out  32; pslverr_o  out  1; all registered.
REQ-015 reg_hw_i  in  G_NUM_REGS*32  read value of RO registers (slice i = register i).
REQ-016 hw_set_i  in  G_NUM_REGS*32  one-cycle set pulses for W1C bits.
REQ-017 reg_q_o  out  G_NUM_REGS*32  current RW register contents (RO slices drive 0).
REQ-018 reg_wr_o  out  G_NUM_REGS  one-cycle pulse per successfully written register.

Function
REQ-019 FSM SHALL have states IDLE and ACCESS; IDLE->ACCESS on psel_i=1 & penable_i=0; ACCESS->IDLE on completion or psel_i=0.
REQ-020 On IDLE->ACCESS edge, wait counter SHALL load G_WAIT_CYCLES; pready_o SHALL load (G_WAIT_CYCLES==0).
REQ-021 In ACCESS with counter>0, counter SHALL decrement each cycle; pready_o SHALL rise on the edge where counter goes 1->0.
REQ-022 Transfer completes at the edge where pready_o=1, psel_i=1, penable_i=1; pready_o and pslverr_o SHALL return to 0 on that edge.
REQ-023 Zero-wait case: pready_o high in the first access cycle; total transfer = 2 cycles.
REQ-024 prdata_o and pslverr_o SHALL be loaded on the same edge that sets pready_o; prdata_o SHALL be 0 at all other times and for writes.
REQ-025 Read data SHALL be reg_hw_i slice for RO registers, stored value for RW registers.
REQ-026 Error SHALL be flagged when paddr_i[1:0]!=0, index>=G_NUM_REGS, write to RO register, or write with G_PRIV_WRITE=1 & pprot_i[0]=0.
REQ-027 Errored read SHALL return prdata_o=0; errored write SHALL change no register and pulse no reg_wr_o.
REQ-028 Valid write SHALL commit on the completion edge: per byte lane with pstrb_i=1, non-W1C bits take pwdata_i, W1C bits with pwdata_i=1 clear.
REQ-029 Valid write SHALL set reg_wr_o[index]=1 for exactly the cycle after the completion edge, including when pstrb_i=0000.
REQ-030 hw_set_i bit=1 on a W1C bit SHALL set it on the next edge; simultaneous set and W1C clear SHALL leave the bit set.
REQ-031 hw_set_i on non-W1C or RO bits SHALL be ignored.
REQ-032 psel_i=0 while in ACCESS SHALL abort: return to IDLE, no write, no reg_wr_o, pready_o=0.

Reset
REQ-033 With preset_n_i=0 at an edge: state IDLE, counter 0, pready_o=0, pslverr_o=0, prdata_o=0, reg_wr_o=0, registers=G_RESET_VALUE.
REQ-034 Reset during ACCESS SHALL abandon the transfer without committing; reset SHALL override hw_set_i.

Verification
REQ-035 G_WAIT_CYCLES=0: write 0xA5A5_1234 strb 1111 to addr 0x04, read back -> pready_o high in access cycle 1, prdata_o=0xA5A5_1234, reg_wr_o[1] pulsed once.
REQ-036 G_WAIT_CYCLES=3: read addr 0x00 -> pready_o rises on 4th access cycle, pslverr_o=0.
REQ-037 Write 0xFFFF_FFFF strb 0101 to register 0 reset 0 -> register=0x00FF_00FF.
REQ-038 Read addr 0x20 (G_NUM_REGS=8), read 0x02, write RO register -> pslverr_o=1, prdata_o=0, no reg_wr_o, no change.
REQ-039 W1C bit 0: hw_set_i pulse -> bit=1; write 0x1 -> bit=0; set coincident with clearing write -> bit stays 1.
REQ-040 preset_n_i=0 mid-ACCESS of a write -> register unchanged, all outputs 0, next transfer completes normally.

Source files
------------

// File: rtl/apb_reg_bank_if.sv
// APB slave-side bus bundle for apb_reg_bank.
// Handshake: a transfer is set up with psel_i=1/penable_i=0, then held with penable_i=1 and all request fields stable until the cycle where pready_o=1; that cycle completes it.
interface apb_reg_bank_if #(
    parameter int ADDR_WIDTH = 8
) ();
    logic [ADDR_WIDTH-1:0] paddr_i;
    logic [2:0]            pprot_i;
    logic                  psel_i;
    logic                  penable_i;
    logic                  pwrite_i;
    logic [31:0]           pwdata_i;
    logic [3:0]            pstrb_i;
    logic                  pready_o;
    logic [31:0]           prdata_o;
    logic                  pslverr_o;

    modport master (
        output paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        input  pready_o, prdata_o, pslverr_o
    );

    modport slave (
        input  paddr_i, pprot_i, psel_i, penable_i, pwrite_i, pwdata_i, pstrb_i,
        output pready_o, prdata_o, pslverr_o
    );
endinterface

// File: rtl/apb_reg_bank.sv
// APB register bank: RW/RO registers, per-bit W1C status bits, programmable wait states,
// registered response and a one-cycle write strobe per register.
module apb_reg_bank #(
    parameter int                         G_APB_ADDR_WIDTH = 8,
    parameter int                         G_NUM_REGS       = 8,
    parameter int                         G_WAIT_CYCLES    = 0,
    parameter logic [G_NUM_REGS-1:0]      G_RO_MASK        = '0,
    parameter logic [G_NUM_REGS*32-1:0]   G_W1C_MASK       = '0,
    parameter logic [G_NUM_REGS*32-1:0]   G_RESET_VALUE    = '0,
    parameter bit                         G_PRIV_WRITE     = 1'b0
) (
    input  logic                       pclk_i,
    input  logic                       preset_n_i,
    apb_reg_bank_if.slave              apb,
    input  logic [G_NUM_REGS*32-1:0]   reg_hw_i,
    input  logic [G_NUM_REGS*32-1:0]   hw_set_i,
    output logic [G_NUM_REGS*32-1:0]   reg_q_o,
    output logic [G_NUM_REGS-1:0]      reg_wr_o,
    output logic                       dbg_state
);
    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_e;

    localparam int IDX_W = G_APB_ADDR_WIDTH - 2;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [31:0]           prdata_q, prdata_d;
    logic [G_NUM_REGS-1:0] reg_wr_q, reg_wr_d;
    logic [31:0]           regs_q [G_NUM_REGS];
    logic [31:0]           regs_d [G_NUM_REGS];

    logic [IDX_W-1:0] idx;
    logic             in_range;
    logic             sel_ro;
    logic [31:0]      sel_data;
    logic             acc_err;
    logic [31:0]      rsp_data;
    logic [31:0]      lane;
    logic             complete;
    logic             commit;
    logic             unused_prot;

    assign idx         = apb.paddr_i[G_APB_ADDR_WIDTH-1:2];
    assign lane        = {{8{apb.pstrb_i[3]}}, {8{apb.pstrb_i[2]}},
                          {8{apb.pstrb_i[1]}}, {8{apb.pstrb_i[0]}}};
    assign unused_prot = ^apb.pprot_i[2:1];

    always_comb begin
        in_range = 1'b0;
        sel_ro   = 1'b0;
        sel_data = '0;
        for (int i = 0; i < G_NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                in_range = 1'b1;
                sel_ro   = G_RO_MASK[i];
                sel_data = G_RO_MASK[i] ? reg_hw_i[i*32 +: 32] : regs_q[i];
            end
        end
    end

    assign acc_err  = (apb.paddr_i[1:0] != 2'b00) | ~in_range |
                      (apb.pwrite_i & (sel_ro | (G_PRIV_WRITE & ~apb.pprot_i[0])));
    assign rsp_data = (acc_err | apb.pwrite_i) ? 32'h0 : sel_data;

    // Response fields are captured together with pready, so they are valid exactly while pready is high.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (apb.psel_i && !apb.penable_i) begin
                    state_d = ACCESS;
                    cnt_d   = 4'(G_WAIT_CYCLES);
                    if (G_WAIT_CYCLES == 0) begin
                        pready_d  = 1'b1;
                        pslverr_d = acc_err;
                        prdata_d  = rsp_data;
                    end
                end
            end
            ACCESS: begin
                if (!apb.psel_i || (pready_q && apb.penable_i)) begin
                    complete  = apb.psel_i;
                    state_d   = IDLE;
                    cnt_d     = 4'd0;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = 32'h0;
                end else if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        pready_d  = 1'b1;
                        pslverr_d = acc_err;
                        prdata_d  = rsp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign commit = complete & apb.pwrite_i & ~pslverr_q;

    // W1C clear is applied before the hardware set so a coincident set wins.
    always_comb begin
        reg_wr_d = '0;
        for (int i = 0; i < G_NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (commit && idx == IDX_W'(i)) begin
                reg_wr_d[i] = 1'b1;
                regs_d[i]   = (regs_q[i] & ~(lane & ~G_W1C_MASK[i*32 +: 32])) |
                              (apb.pwdata_i & lane & ~G_W1C_MASK[i*32 +: 32]);
                regs_d[i]   = regs_d[i] & ~(apb.pwdata_i & lane & G_W1C_MASK[i*32 +: 32]);
            end
            regs_d[i] = regs_d[i] | (hw_set_i[i*32 +: 32] & G_W1C_MASK[i*32 +: 32]);
            if (G_RO_MASK[i]) begin
                regs_d[i] = regs_q[i];
            end
        end
    end

    always_ff @(posedge pclk_i) begin
        if (!preset_n_i) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= 32'h0;
            reg_wr_q  <= '0;
            for (int i = 0; i < G_NUM_REGS; i++) begin
                regs_q[i] <= G_RESET_VALUE[i*32 +: 32];
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            reg_wr_q  <= reg_wr_d;
            for (int i = 0; i < G_NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        reg_q_o = '0;
        for (int i = 0; i < G_NUM_REGS; i++) begin
            reg_q_o[i*32 +: 32] = G_RO_MASK[i] ? 32'h0 : regs_q[i];
        end
    end

    assign apb.pready_o  = pready_q;
    assign apb.prdata_o  = prdata_q;
    assign apb.pslverr_o = pslverr_q;
    assign reg_wr_o      = reg_wr_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_apb_reg_bank.sv
// Bench for apb_reg_bank: two instances (0 and 3 wait states, the latter with privileged writes),
// directed vector table, hand-written corner sequences and a randomized run against a reference model.
module tb_apb_reg_bank;
    localparam logic [7:0]   RO   = 8'h80;
    localparam logic [255:0] W1C  = 256'h000000FF_00000000_00000000;
    localparam logic [255:0] RSTV = 256'hDEADBEEF_00000000_00000000_00000000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [255:0] reg_hw, hw_set;
    logic [255:0] reg_q0, reg_q1;
    logic [7:0]   reg_wr0, reg_wr1;
    logic         dbg0, dbg1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    apb_reg_bank_if #(.ADDR_WIDTH(8)) bus0 ();
    apb_reg_bank_if #(.ADDR_WIDTH(8)) bus1 ();

    apb_reg_bank #(
        .G_APB_ADDR_WIDTH(8), .G_NUM_REGS(8), .G_WAIT_CYCLES(0), .G_RO_MASK(RO),
        .G_W1C_MASK(W1C), .G_RESET_VALUE(RSTV), .G_PRIV_WRITE(1'b0)
    ) dut0 (
        .pclk_i(clk), .preset_n_i(rst_n), .apb(bus0), .reg_hw_i(reg_hw),
        .hw_set_i(hw_set), .reg_q_o(reg_q0), .reg_wr_o(reg_wr0), .dbg_state(dbg0)
    );

    apb_reg_bank #(
        .G_APB_ADDR_WIDTH(8), .G_NUM_REGS(8), .G_WAIT_CYCLES(3), .G_RO_MASK(RO),
        .G_W1C_MASK(W1C), .G_RESET_VALUE(RSTV), .G_PRIV_WRITE(1'b1)
    ) dut1 (
        .pclk_i(clk), .preset_n_i(rst_n), .apb(bus1), .reg_hw_i(reg_hw),
        .hw_set_i(hw_set), .reg_q_o(reg_q1), .reg_wr_o(reg_wr1), .dbg_state(dbg1)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_regs [2][8];

    function automatic void model_reset();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) m_regs[d][i] = RSTV[i*32 +: 32];
    endfunction

    function automatic logic model_err(int d, logic wr, logic [7:0] addr, logic [2:0] prot);
        int idx = int'(addr[7:2]);
        if (addr[1:0] != 2'b00) return 1'b1;
        if (idx >= 8) return 1'b1;
        if (wr && RO[idx]) return 1'b1;
        if (wr && d == 1 && !prot[0]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_read(int d, logic wr, logic [7:0] addr, logic [2:0] prot);
        int idx = int'(addr[7:2]);
        if (wr || model_err(d, wr, addr, prot)) return 32'h0;
        if (RO[idx]) return reg_hw[idx*32 +: 32];
        return m_regs[d][idx];
    endfunction

    function automatic void model_write(int d, logic [7:0] addr, logic [31:0] data, logic [3:0] strb);
        int idx = int'(addr[7:2]);
        for (int b = 0; b < 32; b++) begin
            if (strb[b/8]) begin
                if (W1C[idx*32 + b]) begin
                    if (data[b]) m_regs[d][idx][b] = 1'b0;
                end else begin
                    m_regs[d][idx][b] = data[b];
                end
            end
        end
    endfunction

    function automatic void model_hwset(logic [255:0] set);
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++)
                for (int b = 0; b < 32; b++)
                    if (!RO[i] && W1C[i*32 + b] && set[i*32 + b]) m_regs[d][i][b] = 1'b1;
    endfunction

    function automatic logic [255:0] exp_q(int d);
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = RO[i] ? 32'h0 : m_regs[d][i];
        return v;
    endfunction

    // ---------------- bus access helpers ----------------
    task automatic set_bus(input int d, input logic sel, input logic en, input logic wr,
                           input logic [7:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input logic [2:0] prot);
        if (d == 0) begin
            bus0.psel_i = sel; bus0.penable_i = en; bus0.pwrite_i = wr; bus0.paddr_i = addr;
            bus0.pwdata_i = data; bus0.pstrb_i = strb; bus0.pprot_i = prot;
        end else begin
            bus1.psel_i = sel; bus1.penable_i = en; bus1.pwrite_i = wr; bus1.paddr_i = addr;
            bus1.pwdata_i = data; bus1.pstrb_i = strb; bus1.pprot_i = prot;
        end
    endtask

    function automatic logic get_ready(int d);
        return (d == 0) ? bus0.pready_o : bus1.pready_o;
    endfunction
    function automatic logic [31:0] get_rdata(int d);
        return (d == 0) ? bus0.prdata_o : bus1.prdata_o;
    endfunction
    function automatic logic get_err(int d);
        return (d == 0) ? bus0.pslverr_o : bus1.pslverr_o;
    endfunction
    function automatic logic [7:0] get_wr(int d);
        return (d == 0) ? reg_wr0 : reg_wr1;
    endfunction
    function automatic logic [255:0] get_q(int d);
        return (d == 0) ? reg_q0 : reg_q1;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns just after the completion edge; wr_pulse is reg_wr sampled in the cycle after it.
    task automatic apb_xfer(input int d, input logic wr, input logic [7:0] addr,
                            input logic [31:0] data, input logic [3:0] strb, input logic [2:0] prot,
                            output logic [31:0] rdata, output logic err, output int ncyc,
                            output logic [7:0] wr_pulse);
        @(posedge clk); #1;
        set_bus(d, 1'b1, 1'b0, wr, addr, data, strb, prot);
        @(posedge clk); #1;
        set_bus(d, 1'b1, 1'b1, wr, addr, data, strb, prot);
        ncyc = 1;
        while (!get_ready(d) && ncyc < 40) begin
            @(posedge clk); #1;
            ncyc++;
        end
        check("pready_within_bound", {255'b0, get_ready(d)}, 256'd1);
        rdata = get_rdata(d);
        err   = get_err(d);
        @(posedge clk); #1;
        set_bus(d, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 3'h0);
        wr_pulse = get_wr(d);
    endtask

    typedef struct {
        int          d;
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_wr;
    } vec_t;

    vec_t vecs [15];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rdata;
        logic        err;
        int          ncyc;
        logic [7:0]  wrp;

        vecs[0]  = '{0, 1'b1, 8'h04, 32'hA5A5_1234, 4'hF, 3'd0, 32'h0,         1'b0, 8'h02};
        vecs[1]  = '{0, 1'b0, 8'h04, 32'h0,         4'h0, 3'd0, 32'hA5A5_1234, 1'b0, 8'h00};
        vecs[2]  = '{0, 1'b1, 8'h00, 32'hFFFF_FFFF, 4'h5, 3'd0, 32'h0,         1'b0, 8'h01};
        vecs[3]  = '{0, 1'b0, 8'h00, 32'h0,         4'h0, 3'd0, 32'h00FF_00FF, 1'b0, 8'h00};
        vecs[4]  = '{0, 1'b0, 8'h20, 32'h0,         4'h0, 3'd0, 32'h0,         1'b1, 8'h00};
        vecs[5]  = '{0, 1'b0, 8'h02, 32'h0,         4'h0, 3'd0, 32'h0,         1'b1, 8'h00};
        vecs[6]  = '{0, 1'b1, 8'h1C, 32'h1234_5678, 4'hF, 3'd0, 32'h0,         1'b1, 8'h00};
        vecs[7]  = '{0, 1'b0, 8'h1C, 32'h0,         4'h0, 3'd0, 32'hCAFE_F00D, 1'b0, 8'h00};
        vecs[8]  = '{0, 1'b0, 8'h0C, 32'h0,         4'h0, 3'd0, 32'hDEAD_BEEF, 1'b0, 8'h00};
        vecs[9]  = '{0, 1'b1, 8'h0C, 32'h0,         4'h0, 3'd0, 32'h0,         1'b0, 8'h08};
        vecs[10] = '{0, 1'b0, 8'h0C, 32'h0,         4'h0, 3'd0, 32'hDEAD_BEEF, 1'b0, 8'h00};
        vecs[11] = '{1, 1'b1, 8'h08, 32'h1111_1111, 4'hF, 3'd0, 32'h0,         1'b1, 8'h00};
        vecs[12] = '{1, 1'b1, 8'h10, 32'h0000_0055, 4'h1, 3'd1, 32'h0,         1'b0, 8'h10};
        vecs[13] = '{1, 1'b0, 8'h10, 32'h0,         4'h0, 3'd0, 32'h0000_0055, 1'b0, 8'h00};
        vecs[14] = '{1, 1'b0, 8'h00, 32'h0,         4'h0, 3'd0, 32'h0,         1'b0, 8'h00};

        // ---------------- reset ----------------
        rst_n  = 1'b0;
        hw_set = '0;
        reg_hw = '0;
        reg_hw[224 +: 32] = 32'hCAFE_F00D;
        set_bus(0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 3'h0);
        set_bus(1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 3'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        for (int d = 0; d < 2; d++) begin
            check("reset_pready",  {255'b0, get_ready(d)}, 256'd0);
            check("reset_pslverr", {255'b0, get_err(d)}, 256'd0);
            check("reset_prdata",  get_rdata(d), 256'd0);
            check("reset_reg_wr",  get_wr(d), 256'd0);
            check("reset_reg_q",   get_q(d), exp_q(d));
        end
        check("reset_reg3_value", reg_q0[96 +: 32], 256'hDEAD_BEEF);

        // ---------------- directed vector table ----------------
        for (int v = 0; v < 15; v++) begin
            apb_xfer(vecs[v].d, vecs[v].wr, vecs[v].addr, vecs[v].data, vecs[v].strb,
                     vecs[v].prot, rdata, err, ncyc, wrp);
            check($sformatf("vec%0d_prdata", v), rdata, vecs[v].exp_rdata);
            check($sformatf("vec%0d_pslverr", v), {255'b0, err}, {255'b0, vecs[v].exp_err});
            check($sformatf("vec%0d_access_cycles", v), ncyc, (vecs[v].d == 0) ? 1 : 4);
            check($sformatf("vec%0d_reg_wr", v), wrp, vecs[v].exp_wr);
            check($sformatf("vec%0d_pready_drop", v), {255'b0, get_ready(vecs[v].d)}, 256'd0);
            check($sformatf("vec%0d_prdata_idle", v), get_rdata(vecs[v].d), 256'd0);
            if (vecs[v].wr && !model_err(vecs[v].d, vecs[v].wr, vecs[v].addr, vecs[v].prot))
                model_write(vecs[v].d, vecs[v].addr, vecs[v].data, vecs[v].strb);
            check($sformatf("vec%0d_reg_q", v), get_q(vecs[v].d), exp_q(vecs[v].d));
            @(posedge clk); #1;
            check($sformatf("vec%0d_reg_wr_single", v), get_wr(vecs[v].d), 256'd0);
        end
        check("reg0_strobed_value", reg_q0[0 +: 32], 256'h00FF_00FF);

        // ---------------- W1C: set, clear, coincident set/clear ----------------
        hw_set[64] = 1'b1;
        hw_set[72] = 1'b1;
        hw_set[224] = 1'b1;
        @(posedge clk); #1;
        model_hwset(hw_set);
        hw_set = '0;
        check("w1c_hw_set", reg_q0[64 +: 32], 256'h1);
        check("w1c_hw_set_model", reg_q1, exp_q(1));
        apb_xfer(0, 1'b1, 8'h08, 32'h1, 4'h1, 3'd0, rdata, err, ncyc, wrp);
        model_write(0, 8'h08, 32'h1, 4'h1);
        check("w1c_clear", reg_q0[64 +: 32], 256'h0);
        check("w1c_clear_wr", wrp, 256'h04);
        hw_set[64] = 1'b1;
        apb_xfer(0, 1'b1, 8'h08, 32'h1, 4'h1, 3'd0, rdata, err, ncyc, wrp);
        hw_set = '0;
        model_write(0, 8'h08, 32'h1, 4'h1);
        model_hwset(256'h1 << 64);
        check("w1c_set_wins", reg_q0[64 +: 32], 256'h1);
        check("w1c_set_wins_model", reg_q0, exp_q(0));

        // ---------------- abort by psel drop ----------------
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b0, 1'b1, 8'h14, 32'hAAAA_AAAA, 4'hF, 3'd1);
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b1, 8'h14, 32'hAAAA_AAAA, 4'hF, 3'd1);
        @(posedge clk); #1;
        set_bus(1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 3'h0);
        @(posedge clk); #1;
        check("abort_pready", {255'b0, get_ready(1)}, 256'd0);
        check("abort_idle", {255'b0, dbg1}, 256'd0);
        check("abort_reg_wr", get_wr(1), 256'd0);
        @(posedge clk); #1;
        check("abort_reg_wr_late", get_wr(1), 256'd0);
        check("abort_reg_q", reg_q1, exp_q(1));

        // ---------------- reset in the middle of an access ----------------
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b0, 1'b1, 8'h0C, 32'h1111_1111, 4'hF, 3'd1);
        @(posedge clk); #1;
        set_bus(1, 1'b1, 1'b1, 1'b1, 8'h0C, 32'h1111_1111, 4'hF, 3'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        hw_set[64] = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        hw_set = '0;
        set_bus(1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 4'h0, 3'h0);
        model_reset();
        check("midrst_pready", {255'b0, get_ready(1)}, 256'd0);
        check("midrst_pslverr", {255'b0, get_err(1)}, 256'd0);
        check("midrst_prdata", get_rdata(1), 256'd0);
        check("midrst_reg_wr", get_wr(1), 256'd0);
        check("midrst_state", {255'b0, dbg1}, 256'd0);
        check("midrst_reg3", reg_q1[96 +: 32], 256'hDEAD_BEEF);
        check("rst_over_hwset", reg_q0[64 +: 32], 256'h0);
        @(posedge clk); #1;
        check("midrst_reg_wr_late", get_wr(1), 256'd0);
        apb_xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, 3'd0, rdata, err, ncyc, wrp);
        check("post_rst_read", rdata, 256'hDEAD_BEEF);
        check("post_rst_err", {255'b0, err}, 256'd0);
        check("post_rst_cycles", ncyc, 256'd4);

        // ---------------- randomized run against the model ----------------
        for (int n = 0; n < 80; n++) begin
            int          d;
            logic        wr;
            logic [7:0]  addr;
            logic [31:0] data;
            logic [3:0]  strb;
            logic [2:0]  prot;
            logic [31:0] e_rd;
            logic        e_err;
            logic [7:0]  e_wr;
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < 8; i++) hw_set[i*32 +: 32] = $urandom;
                @(posedge clk); #1;
                model_hwset(hw_set);
                hw_set = '0;
            end
            reg_hw[224 +: 32] = $urandom;
            d    = int'($urandom_range(0, 1));
            wr   = 1'($urandom_range(0, 1));
            addr = 8'($urandom_range(0, 9) * 4);
            if ($urandom_range(0, 7) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            data = $urandom;
            strb = 4'($urandom_range(0, 15));
            prot = 3'($urandom_range(0, 7));
            e_err = model_err(d, wr, addr, prot);
            e_rd  = model_read(d, wr, addr, prot);
            e_wr  = (wr && !e_err) ? (8'h01 << addr[7:2]) : 8'h00;
            apb_xfer(d, wr, addr, data, strb, prot, rdata, err, ncyc, wrp);
            if (wr && !e_err) model_write(d, addr, data, strb);
            check($sformatf("rnd%0d_prdata", n), rdata, e_rd);
            check($sformatf("rnd%0d_pslverr", n), {255'b0, err}, {255'b0, e_err});
            check($sformatf("rnd%0d_reg_wr", n), wrp, e_wr);
            check($sformatf("rnd%0d_reg_q", n), get_q(d), exp_q(d));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
